// File: rtl/y86_mem_wb_stage_if.sv
// Bundle, commit and decode-read signals of the Y86-64 memory/writeback stage.
// The master side (execute/decode) drives a bundle and read addresses.
// The slave side (the stage) returns the commit results and the read data.
interface y86_mem_wb_stage_if #(
  parameter int WORD_W = 64
);
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        icode;
  logic [3:0]        rA;
  logic [3:0]        rB;
  logic              cnd;
  logic [WORD_W-1:0] valA;
  logic [WORD_W-1:0] valE;
  logic [WORD_W-1:0] valC;
  logic [WORD_W-1:0] valP;
  logic [3:0]        rd_addr_a;
  logic [3:0]        rd_addr_b;
  logic [WORD_W-1:0] rd_data_a;
  logic [WORD_W-1:0] rd_data_b;
  logic              out_valid;
  logic [WORD_W-1:0] new_pc;
  logic [WORD_W-1:0] valM;
  logic [1:0]        stat;

  modport master (
    output in_valid, icode, rA, rB, cnd, valA, valE, valC, valP, rd_addr_a, rd_addr_b,
    input  in_ready, rd_data_a, rd_data_b, out_valid, new_pc, valM, stat
  );

  modport slave (
    input  in_valid, icode, rA, rB, cnd, valA, valE, valC, valP, rd_addr_a, rd_addr_b,
    output in_ready, rd_data_a, rd_data_b, out_valid, new_pc, valM, stat
  );
endinterface

// File: rtl/y86_mem_wb_stage.sv
// SEQ Y86-64 memory / writeback / PC-select stage.
// Owns the register file and the data memory. Each accepted bundle runs
// IDLE -> MEM (memory access) -> WB (register and PC commit). Any non-AOK
// status parks the stage in HALT until reset.
module y86_mem_wb_stage #(
  parameter int WORD_W     = 64,
  parameter int DMEM_DEPTH = 256,
  parameter int NREGS      = 15,
  parameter int RSP_IDX    = 4
) (
  input logic              clk,
  input logic              rst_n,
  y86_mem_wb_stage_if.slave bus
);

  localparam int AW = $clog2(DMEM_DEPTH);

  localparam logic [1:0] STAT_AOK = 2'd0;
  localparam logic [1:0] STAT_HLT = 2'd1;
  localparam logic [1:0] STAT_ADR = 2'd2;
  localparam logic [1:0] STAT_INS = 2'd3;

  localparam logic [3:0] REG_NONE = 4'hF;
  localparam logic [3:0] REG_RSP  = 4'(RSP_IDX);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MEM  = 2'd1,
    ST_WB   = 2'd2,
    ST_HALT = 2'd3
  } state_t;

  // Word-aligned and inside the data memory.
  function automatic logic addr_legal(input logic [WORD_W-1:0] a);
    return (a[2:0] == 3'd0) && (a[WORD_W-1:AW+3] == {(WORD_W-AW-3){1'b0}});
  endfunction

  // A register index that names a real register file entry.
  function automatic logic reg_ok(input logic [3:0] idx);
    return (idx != REG_NONE) && ({28'd0, idx} < 32'(NREGS));
  endfunction

  state_t            state_r;
  state_t            state_next_s;

  logic [3:0]        icode_r;
  logic [3:0]        ra_r;
  logic [3:0]        rb_r;
  logic              cnd_r;
  logic [WORD_W-1:0] vala_r;
  logic [WORD_W-1:0] vale_r;
  logic [WORD_W-1:0] valc_r;
  logic [WORD_W-1:0] valp_r;

  logic [WORD_W-1:0] regs_r [NREGS];
  logic [WORD_W-1:0] dmem_r [DMEM_DEPTH];

  logic [WORD_W-1:0] valm_r;
  logic [WORD_W-1:0] new_pc_r;
  logic [1:0]        stat_r;
  logic              out_valid_r;
  logic              in_ready_r;

  logic              mem_rd_s;
  logic              mem_wr_s;
  logic [WORD_W-1:0] mem_addr_s;
  logic [WORD_W-1:0] mem_wdata_s;
  logic [AW-1:0]     mem_idx_s;
  logic              addr_ok_s;
  logic [3:0]        dst_e_s;
  logic [3:0]        dst_m_s;
  logic [WORD_W-1:0] pc_next_s;
  logic              halt_s;
  logic              icode_bad_s;
  logic [1:0]        stat_next_s;
  logic              commit_ok_s;
  logic              we_e_s;
  logic              we_m_s;
  logic [WORD_W-1:0] rd_a_s;
  logic [WORD_W-1:0] rd_b_s;

  // Decode the latched bundle into memory access, register destinations and next PC.
  always_comb begin
    mem_rd_s    = 1'b0;
    mem_wr_s    = 1'b0;
    mem_addr_s  = vale_r;
    mem_wdata_s = vala_r;
    dst_e_s     = REG_NONE;
    dst_m_s     = REG_NONE;
    pc_next_s   = valp_r;
    halt_s      = 1'b0;
    icode_bad_s = 1'b0;
    case (icode_r)
      4'h0: halt_s = 1'b1;
      4'h1: pc_next_s = valp_r;
      4'h2: begin
        if (cnd_r) begin
          dst_e_s = rb_r;
        end else begin
          dst_e_s = REG_NONE;
        end
      end
      4'h3: dst_e_s = rb_r;
      4'h4: mem_wr_s = 1'b1;
      4'h5: begin
        mem_rd_s = 1'b1;
        dst_m_s  = ra_r;
      end
      4'h6: dst_e_s = rb_r;
      4'h7: pc_next_s = cnd_r ? valc_r : valp_r;
      4'h8: begin
        mem_wr_s    = 1'b1;
        mem_wdata_s = valp_r;
        dst_e_s     = REG_RSP;
        pc_next_s   = valc_r;
      end
      4'h9: begin
        mem_rd_s   = 1'b1;
        mem_addr_s = vala_r;
        dst_e_s    = REG_RSP;
        pc_next_s  = valm_r;  // valm_r already holds the return address in WB
      end
      4'hA: begin
        mem_wr_s = 1'b1;
        dst_e_s  = REG_RSP;
      end
      4'hB: begin
        mem_rd_s   = 1'b1;
        mem_addr_s = vala_r;
        dst_e_s    = REG_RSP;
        dst_m_s    = ra_r;
      end
      default: icode_bad_s = 1'b1;
    endcase
  end

  assign addr_ok_s = addr_legal(mem_addr_s);
  assign mem_idx_s = mem_addr_s[AW+2:3];

  // Resolve the status this bundle commits with; instruction faults take priority.
  always_comb begin
    stat_next_s = STAT_AOK;
    if (icode_bad_s) begin
      stat_next_s = STAT_INS;
    end else if (halt_s) begin
      stat_next_s = STAT_HLT;
    end else if ((mem_rd_s || mem_wr_s) && !addr_ok_s) begin
      stat_next_s = STAT_ADR;
    end else begin
      stat_next_s = STAT_AOK;
    end
  end

  assign commit_ok_s = (state_r == ST_WB) && (stat_next_s == STAT_AOK);
  assign we_e_s      = commit_ok_s && reg_ok(dst_e_s);
  assign we_m_s      = commit_ok_s && reg_ok(dst_m_s);

  // Next-state logic of the IDLE -> MEM -> WB sequence.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.in_valid) begin
          state_next_s = ST_MEM;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_MEM: state_next_s = ST_WB;
      ST_WB: begin
        if (stat_next_s == STAT_AOK) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_HALT;
        end
      end
      ST_HALT: state_next_s = ST_HALT;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Latch the incoming bundle on the accepting edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      icode_r <= 4'h1;
      ra_r    <= 4'hF;
      rb_r    <= 4'hF;
      cnd_r   <= 1'b0;
      vala_r  <= {WORD_W{1'b0}};
      vale_r  <= {WORD_W{1'b0}};
      valc_r  <= {WORD_W{1'b0}};
      valp_r  <= {WORD_W{1'b0}};
    end else if ((state_r == ST_IDLE) && bus.in_valid) begin
      icode_r <= bus.icode;
      ra_r    <= bus.rA;
      rb_r    <= bus.rB;
      cnd_r   <= bus.cnd;
      vala_r  <= bus.valA;
      vale_r  <= bus.valE;
      valc_r  <= bus.valC;
      valp_r  <= bus.valP;
    end
  end

  // Data memory write in the MEM cycle; contents survive reset.
  always_ff @(posedge clk) begin
    if ((state_r == ST_MEM) && mem_wr_s && addr_ok_s && !icode_bad_s) begin
      dmem_r[mem_idx_s] <= mem_wdata_s;
    end
  end

  // Capture memory read data in the MEM cycle, only for a legal address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valm_r <= {WORD_W{1'b0}};
    end else if ((state_r == ST_MEM) && mem_rd_s && addr_ok_s) begin
      valm_r <= dmem_r[mem_idx_s];
    end
  end

  // Register file commit in WB; the memory-port write is applied last so it wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_r[i] <= {WORD_W{1'b0}};
      end
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (we_e_s && (dst_e_s == 4'(i))) begin
          regs_r[i] <= vale_r;
        end
        if (we_m_s && (dst_m_s == 4'(i))) begin
          regs_r[i] <= valm_r;
        end
      end
    end
  end

  // Commit outputs: status, PC, commit pulse and ready flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_r      <= STAT_AOK;
      new_pc_r    <= {WORD_W{1'b0}};
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
    end else begin
      out_valid_r <= (state_r == ST_WB);
      in_ready_r  <= (state_next_s == ST_IDLE);
      if (state_r == ST_WB) begin
        stat_r <= stat_next_s;
        if (stat_next_s == STAT_AOK) begin
          new_pc_r <= pc_next_s;
        end
      end
    end
  end

  // Decode read ports; unknown or out-of-range indices read as zero.
  always_comb begin
    rd_a_s = {WORD_W{1'b0}};
    rd_b_s = {WORD_W{1'b0}};
    for (int i = 0; i < NREGS; i++) begin
      if (bus.rd_addr_a == 4'(i)) begin
        rd_a_s = regs_r[i];
      end else begin
        rd_a_s = rd_a_s;
      end
      if (bus.rd_addr_b == 4'(i)) begin
        rd_b_s = regs_r[i];
      end else begin
        rd_b_s = rd_b_s;
      end
    end
  end

  assign bus.rd_data_a = rd_a_s;
  assign bus.rd_data_b = rd_b_s;
  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.new_pc    = new_pc_r;
  assign bus.valM      = valm_r;
  assign bus.stat      = stat_r;

endmodule

// File: tb/tb_y86_mem_wb_stage.sv
// Directed bench for y86_mem_wb_stage: hand-computed expectations for each bundle.
module tb_y86_mem_wb_stage;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  y86_mem_wb_stage_if #(.WORD_W(64)) bus ();

  y86_mem_wb_stage #(
    .WORD_W(64), .DMEM_DEPTH(256), .NREGS(15), .RSP_IDX(4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic read_reg(input logic [3:0] idx, output logic [63:0] val);
    bus.rd_addr_a = idx;
    #1;
    val = bus.rd_data_a;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
  endtask

  // Presents one bundle, then waits (bounded) for its commit pulse.
  task automatic run_bundle(input logic [3:0] icode, input logic [3:0] ra, input logic [3:0] rb,
                            input logic cnd, input logic [63:0] va, input logic [63:0] ve,
                            input logic [63:0] vc, input logic [63:0] vp);
    int cyc;
    @(negedge clk);
    bus.icode = icode; bus.rA = ra; bus.rB = rb; bus.cnd = cnd;
    bus.valA = va; bus.valE = ve; bus.valC = vc; bus.valP = vp;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    cyc = 0;
    while (!bus.out_valid && cyc < 8) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check_eq("commit_latency", 64'(cyc), 64'd2);
  endtask

  logic [63:0] rv;
  int          ov_cnt;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n = 1'b1;
    bus.in_valid = 1'b0; bus.icode = 4'h1; bus.rA = 4'hF; bus.rB = 4'hF; bus.cnd = 1'b0;
    bus.valA = 64'd0; bus.valE = 64'd0; bus.valC = 64'd0; bus.valP = 64'd0;
    bus.rd_addr_a = 4'h0; bus.rd_addr_b = 4'h0;
    #2 rst_n = 1'b0;
    #10;
    check_eq("rst_stat", 64'(bus.stat), 64'd0);
    check_eq("rst_new_pc", bus.new_pc, 64'd0);
    check_eq("rst_valM", bus.valM, 64'd0);
    check_eq("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check_eq("rst_in_ready", 64'(bus.in_ready), 64'd1);
    read_reg(4'd2, rv); check_eq("rst_r2", rv, 64'd0);
    #3 rst_n = 1'b1;

    // irmovq $0x55, %r2
    run_bundle(4'h3, 4'hF, 4'd2, 1'b0, 64'd0, 64'h55, 64'd0, 64'h0A);
    read_reg(4'd2, rv); check_eq("irmovq_r2", rv, 64'h55);
    check_eq("irmovq_stat", 64'(bus.stat), 64'd0);
    check_eq("irmovq_pc", bus.new_pc, 64'h0A);
    check_eq("irmovq_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;
    check_eq("out_valid_one_cycle", 64'(bus.out_valid), 64'd0);

    // rmmovq then mrmovq through address 0x10
    run_bundle(4'h4, 4'hF, 4'hF, 1'b0, 64'hABCD, 64'h10, 64'd0, 64'h14);
    check_eq("rmmovq_pc", bus.new_pc, 64'h14);
    run_bundle(4'h5, 4'd3, 4'hF, 1'b0, 64'd0, 64'h10, 64'd0, 64'h1E);
    check_eq("mrmovq_valM", bus.valM, 64'hABCD);
    read_reg(4'd3, rv); check_eq("mrmovq_r3", rv, 64'hABCD);

    // call / ret
    run_bundle(4'h8, 4'hF, 4'hF, 1'b0, 64'd0, 64'h78, 64'h40, 64'h20);
    check_eq("call_pc", bus.new_pc, 64'h40);
    read_reg(4'd4, rv); check_eq("call_rsp", rv, 64'h78);
    run_bundle(4'h9, 4'hF, 4'hF, 1'b0, 64'h78, 64'h80, 64'd0, 64'h22);
    check_eq("ret_pc", bus.new_pc, 64'h20);
    read_reg(4'd4, rv); check_eq("ret_rsp", rv, 64'h80);

    // popq %rsp: memory-port write must beat the stack-pointer update
    run_bundle(4'h4, 4'hF, 4'hF, 1'b0, 64'h99, 64'h78, 64'd0, 64'h2A);
    run_bundle(4'hB, 4'd4, 4'hF, 1'b0, 64'h78, 64'h80, 64'd0, 64'h2C);
    read_reg(4'd4, rv); check_eq("popq_rsp_valM_wins", rv, 64'h99);

    // cmovxx not taken / taken
    run_bundle(4'h2, 4'hF, 4'd2, 1'b0, 64'd0, 64'h77, 64'd0, 64'h2E);
    read_reg(4'd2, rv); check_eq("cmov_nt_r2", rv, 64'h55);
    run_bundle(4'h2, 4'hF, 4'd5, 1'b1, 64'd0, 64'h33, 64'd0, 64'h30);
    read_reg(4'd5, rv); check_eq("cmov_t_r5", rv, 64'h33);

    // jxx taken / not taken
    run_bundle(4'h7, 4'hF, 4'hF, 1'b1, 64'd0, 64'd0, 64'h300, 64'h32);
    check_eq("jxx_taken_pc", bus.new_pc, 64'h300);
    run_bundle(4'h7, 4'hF, 4'hF, 1'b0, 64'd0, 64'd0, 64'h400, 64'h34);
    check_eq("jxx_nt_pc", bus.new_pc, 64'h34);

    // OPq, pushq, and a load with no destination register
    run_bundle(4'h6, 4'hF, 4'd6, 1'b0, 64'd0, 64'h1234, 64'd0, 64'h36);
    read_reg(4'd6, rv); check_eq("opq_r6", rv, 64'h1234);
    run_bundle(4'hA, 4'hF, 4'hF, 1'b0, 64'h5A, 64'h70, 64'd0, 64'h38);
    read_reg(4'd4, rv); check_eq("pushq_rsp", rv, 64'h70);
    run_bundle(4'h5, 4'hF, 4'hF, 1'b0, 64'd0, 64'h70, 64'd0, 64'h3A);
    check_eq("pushq_mem_valM", bus.valM, 64'h5A);
    read_reg(4'hF, rv); check_eq("rd_none_zero", rv, 64'd0);

    // Load just past the end of memory: ADR, valM and PC hold, HALT entered
    run_bundle(4'h5, 4'd1, 4'hF, 1'b0, 64'd0, 64'h800, 64'd0, 64'h3C);
    check_eq("oob_stat", 64'(bus.stat), 64'd2);
    check_eq("oob_valM_hold", bus.valM, 64'h5A);
    check_eq("oob_pc_hold", bus.new_pc, 64'h3A);
    check_eq("halt_entry_in_ready", 64'(bus.in_ready), 64'd0);
    read_reg(4'd1, rv); check_eq("oob_r1", rv, 64'd0);
    @(negedge clk);
    bus.in_valid = 1'b1;
    ov_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.out_valid) ov_cnt++;
    end
    bus.in_valid = 1'b0;
    check_eq("halt_no_out_valid", 64'(ov_cnt), 64'd0);
    check_eq("halt_in_ready", 64'(bus.in_ready), 64'd0);
    check_eq("halt_stat", 64'(bus.stat), 64'd2);

    reset_dut();
    #1;
    check_eq("rerst_stat", 64'(bus.stat), 64'd0);
    check_eq("rerst_in_ready", 64'(bus.in_ready), 64'd1);
    read_reg(4'd4, rv); check_eq("rerst_r4", rv, 64'd0);

    // Reset during the MEM cycle abandons an irmovq
    @(negedge clk);
    bus.icode = 4'h3; bus.rB = 4'd7; bus.valE = 64'h66; bus.valP = 64'h40;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    ov_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.out_valid) ov_cnt++;
    end
    check_eq("abandon_no_commit", 64'(ov_cnt), 64'd0);
    read_reg(4'd7, rv); check_eq("abandon_r7", rv, 64'd0);

    // Misaligned store: ADR and memory untouched
    run_bundle(4'h4, 4'hF, 4'hF, 1'b0, 64'hDEAD, 64'h13, 64'd0, 64'h42);
    check_eq("misalign_stat", 64'(bus.stat), 64'd2);
    reset_dut();
    run_bundle(4'h5, 4'd3, 4'hF, 1'b0, 64'd0, 64'h10, 64'd0, 64'h44);
    check_eq("misalign_mem_intact", bus.valM, 64'hABCD);

    // halt instruction, then an invalid icode
    run_bundle(4'h0, 4'hF, 4'hF, 1'b0, 64'd0, 64'd0, 64'd0, 64'h50);
    check_eq("halt_stat_hlt", 64'(bus.stat), 64'd1);
    check_eq("halt_pc_hold", bus.new_pc, 64'h44);
    reset_dut();
    run_bundle(4'hC, 4'hF, 4'd2, 1'b0, 64'd0, 64'h11, 64'd0, 64'h60);
    check_eq("ins_stat", 64'(bus.stat), 64'd3);
    read_reg(4'd2, rv); check_eq("ins_r2", rv, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
